// File: rtl/nn_train_sequencer.sv
// Initiator for the TR/VL command interface: issues one-cycle command pulses,
// follows the returned phase bus to completion and walks samples across epochs.
module nn_train_sequencer #(
  parameter int N_TRAIN = 16,
  parameter int N_VAL   = 4,
  parameter int N_EPOCH = 8,
  parameter int ADDR_W  = 8,
  parameter int EPOCH_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               FPH,
  input  logic               FPO,
  input  logic               BPH,
  input  logic               BPO,
  output logic               TR,
  output logic               VL,
  output logic [ADDR_W-1:0]  sample_addr,
  output logic               is_val,
  output logic [EPOCH_W-1:0] epoch,
  output logic               sample_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]  LAST_TRAIN = ADDR_W'(N_TRAIN - 1);
  localparam logic [ADDR_W-1:0]  FIRST_VAL  = ADDR_W'(N_TRAIN);
  localparam logic [ADDR_W-1:0]  LAST_VAL   = ADDR_W'(N_TRAIN + N_VAL - 1);
  localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(N_EPOCH - 1);
  localparam bit                 HAS_VAL    = (N_VAL > 0);

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NO_BPO  = 2'b10;
  localparam logic [1:0] ERR_VAL_BWD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACT, S_WAIT_DONE, S_ADVANCE, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               seen_bpo_q, seen_n;
  logic               abort_q, abort_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [EPOCH_W-1:0] epoch_n;
  logic               is_val_n, done_n, err_n;
  logic [1:0]         code_n;
  logic               tr_n, vl_n, sdone_n, busy_n;

  logic phase, busy_st, abort_now, timeout_hit, last_train, last_val, end_epoch;

  assign phase       = FPH | FPO | BPH | BPO;
  assign busy_st     = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign abort_now   = abort_q | abort;
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign last_train  = !is_val && (sample_addr == LAST_TRAIN);
  assign last_val    = is_val && (sample_addr == LAST_VAL);
  assign end_epoch   = (last_train && !HAS_VAL) || last_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    addr_n   = sample_addr;
    is_val_n = is_val;
    epoch_n  = epoch;
    done_n   = done;
    err_n    = err;
    code_n   = err_code;
    cnt_n    = cnt_q;
    seen_n   = seen_bpo_q;
    abort_n  = abort_q | (abort & busy_st);
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_n  = S_ISSUE;
          addr_n   = '0;
          epoch_n  = '0;
          is_val_n = 1'b0;
          done_n   = 1'b0;
          err_n    = 1'b0;
          code_n   = 2'b00;
          abort_n  = 1'b0;
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        seen_n  = 1'b0;
        state_n = abort_now ? S_DRAIN : S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        // An abort here wins over an arriving phase so the sample is drained, not completed.
        if (abort_now) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else if (phase) begin
          state_n = S_WAIT_DONE;
          cnt_n   = '0;
        end else if (timeout_hit) begin
          state_n = S_ERROR;
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (BPO) seen_n = 1'b1;
        if (is_val && (BPH || BPO)) begin
          state_n = S_ERROR;
          err_n   = 1'b1;
          code_n  = ERR_VAL_BWD;
        end else if (!phase) begin
          if (!is_val && !seen_bpo_q) begin
            state_n = S_ERROR;
            err_n   = 1'b1;
            code_n  = ERR_NO_BPO;
          end else begin
            state_n = S_ADVANCE;
          end
        end else if (timeout_hit) begin
          state_n = S_ERROR;
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_ADVANCE: begin
        if (abort_now) begin
          state_n = S_IDLE;
          abort_n = 1'b0;
        end else if (end_epoch) begin
          if (epoch == LAST_EPOCH) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n  = S_ISSUE;
            epoch_n  = epoch + EPOCH_W'(1);
            addr_n   = '0;
            is_val_n = 1'b0;
          end
        end else if (last_train) begin
          state_n  = S_ISSUE;
          addr_n   = FIRST_VAL;
          is_val_n = 1'b1;
        end else begin
          state_n = S_ISSUE;
          addr_n  = sample_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // The controller is left to finish on its own; no completion or error is reported.
        if (!phase || timeout_hit) begin
          state_n = S_IDLE;
          abort_n = 1'b0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    tr_n    = (state_n == S_ISSUE) && !is_val_n;
    vl_n    = (state_n == S_ISSUE) && is_val_n;
    sdone_n = (state_n == S_ADVANCE);
    busy_n  = !(state_n == S_IDLE || state_n == S_DONE || state_n == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_addr <= '0;
      is_val      <= 1'b0;
      epoch       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      cnt_q       <= '0;
      seen_bpo_q  <= 1'b0;
      abort_q     <= 1'b0;
      TR          <= 1'b0;
      VL          <= 1'b0;
      sample_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sample_addr <= addr_n;
      is_val      <= is_val_n;
      epoch       <= epoch_n;
      done        <= done_n;
      err         <= err_n;
      err_code    <= code_n;
      cnt_q       <= cnt_n;
      seen_bpo_q  <= seen_n;
      abort_q     <= abort_n;
      TR          <= tr_n;
      VL          <= vl_n;
      sample_done <= sdone_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Bench for nn_train_sequencer: two configurations driven by a randomized phase
// controller model, with command logs compared against the expected epoch walk.
module tb_nn_train_sequencer;

  localparam int TO       = 10;
  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_NOBPO  = 2;
  localparam int M_BPHVAL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [2];
  logic       abort [2];
  logic [3:0] ph    [2];
  logic       tr    [2];
  logic       vl    [2];
  logic       sdone [2];
  logic       busy  [2];
  logic       done  [2];
  logic       err   [2];
  logic       is_val[2];
  logic [1:0] code  [2];
  logic [7:0] addr  [2];
  logic [7:0] epoch [2];

  int checks   = 0;
  int failures = 0;
  int mode [2];

  logic [3:0] seq  [2][16];
  int         slen [2];
  int         spos [2];

  int   ncmd [2] = '{0, 0};
  int   nsd  [2] = '{0, 0};
  int   viol [2] = '{0, 0};
  logic prev_tr [2] = '{1'b0, 1'b0};
  logic prev_vl [2] = '{1'b0, 1'b0};
  logic log_val [2][64];
  logic log_isv [2][64];
  int   log_addr[2][64];
  int   log_ep  [2][64];

  nn_train_sequencer #(.N_TRAIN(2), .N_VAL(1), .N_EPOCH(2), .ADDR_W(8), .EPOCH_W(8), .TIMEOUT(TO)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .FPH(ph[0][3]), .FPO(ph[0][2]), .BPH(ph[0][1]), .BPO(ph[0][0]),
    .TR(tr[0]), .VL(vl[0]), .sample_addr(addr[0]), .is_val(is_val[0]), .epoch(epoch[0]),
    .sample_done(sdone[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .err_code(code[0])
  );

  nn_train_sequencer #(.N_TRAIN(3), .N_VAL(0), .N_EPOCH(1), .ADDR_W(8), .EPOCH_W(8), .TIMEOUT(TO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .FPH(ph[1][3]), .FPO(ph[1][2]), .BPH(ph[1][1]), .BPO(ph[1][0]),
    .TR(tr[1]), .VL(vl[1]), .sample_addr(addr[1]), .is_val(is_val[1]), .epoch(epoch[1]),
    .sample_done(sdone[1]), .busy(busy[1]), .done(done[1]), .err(err[1]), .err_code(code[1])
  );

  function automatic int ntr(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int nvl(input int i); return (i == 0) ? 1 : 0; endfunction
  function automatic int nep(input int i); return (i == 0) ? 2 : 1; endfunction

  // Controller model: random-length FPH/FPO/backward windows, one phase word per cycle.
  task automatic build_seq(input int i, input logic val);
    int n, d1, d2, d3;
    n  = 0;
    d1 = int'($urandom_range(3, 1));
    d2 = int'($urandom_range(2, 1));
    d3 = int'($urandom_range(2, 1));
    for (int k = 0; k < d1; k++) begin seq[i][n] = 4'b1000; n++; end
    for (int k = 0; k < d2; k++) begin seq[i][n] = 4'b0100; n++; end
    if (!val) begin
      if (mode[i] == M_NOBPO) begin
        seq[i][n] = 4'b0100; n++;
      end else begin
        for (int k = 0; k < d3; k++) begin seq[i][n] = 4'b0001; n++; end
        seq[i][n] = 4'b0011; n++;
        seq[i][n] = 4'b0001; n++;
      end
    end else if (mode[i] == M_BPHVAL) begin
      seq[i][n] = 4'b0010; n++;
    end
    slen[i] = n;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ph[i] = 4'b0000; slen[i] = 0; spos[i] = 0;
      end else if (tr[i] || vl[i]) begin
        ph[i] = 4'b0000; spos[i] = 0; slen[i] = 0;
        if (mode[i] != M_SILENT) build_seq(i, vl[i]);
      end else if (spos[i] < slen[i]) begin
        ph[i] = seq[i][spos[i]];
        spos[i] = spos[i] + 1;
      end else begin
        ph[i] = 4'b0000;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (tr[i] || vl[i]) begin
          log_val[i][ncmd[i]]  = vl[i];
          log_isv[i][ncmd[i]]  = is_val[i];
          log_addr[i][ncmd[i]] = int'(addr[i]);
          log_ep[i][ncmd[i]]   = int'(epoch[i]);
          if (ncmd[i] < 63) ncmd[i] = ncmd[i] + 1;
        end
        if (sdone[i]) nsd[i] = nsd[i] + 1;
        if ((tr[i] && vl[i]) || (tr[i] && prev_tr[i]) || (vl[i] && prev_vl[i])) viol[i] = viol[i] + 1;
        prev_tr[i] = tr[i];
        prev_vl[i] = vl[i];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({tr[i], vl[i], sdone[i], busy[i], done[i], err[i], is_val[i], code[i], addr[i], epoch[i]} !== 25'd0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got=%h expected=0", i,
                 {tr[i], vl[i], sdone[i], busy[i], done[i], err[i], is_val[i], code[i], addr[i], epoch[i]});
      end
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy[0] !== 1'b0 || tr[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle busy=%b tr=%b expected 0 0", busy[0], tr[0]);
    end
  endtask

  task automatic test_full_run(input int i, input string name);
    int base, sd0, v0, n, k, nexp;
    mode[i] = M_NORMAL;
    base = ncmd[i]; sd0 = nsd[i]; v0 = viol[i];
    nexp = nep(i) * (ntr(i) + nvl(i));
    start[i] = 1'b1; tick(); start[i] = 1'b0;
    n = 0;
    while (!done[i] && n < 3000) begin tick(); n++; end
    checks++;
    if (done[i] !== 1'b1) begin failures++; $display("FAIL %s_done got=%b expected=1", name, done[i]); end
    checks++;
    if (err[i] !== 1'b0 || busy[i] !== 1'b0) begin
      failures++; $display("FAIL %s_status err=%b busy=%b expected 0 0", name, err[i], busy[i]);
    end
    checks++;
    if (int'(epoch[i]) != nep(i) - 1) begin
      failures++; $display("FAIL %s_epoch got=%0d expected=%0d", name, epoch[i], nep(i) - 1);
    end
    checks++;
    if (ncmd[i] - base != nexp) begin
      failures++; $display("FAIL %s_cmd_count got=%0d expected=%0d", name, ncmd[i] - base, nexp);
    end
    k = base;
    for (int e = 0; e < nep(i); e++) begin
      for (int a = 0; a < ntr(i) + nvl(i); a++) begin
        checks++;
        if (k >= ncmd[i] || log_val[i][k] !== 1'(a >= ntr(i)) || log_isv[i][k] !== 1'(a >= ntr(i)) ||
            log_addr[i][k] != a || log_ep[i][k] != e) begin
          failures++;
          $display("FAIL %s_cmd%0d got vl=%b addr=%0d epoch=%0d expected vl=%b addr=%0d epoch=%0d",
                   name, k - base, log_val[i][k], log_addr[i][k], log_ep[i][k], a >= ntr(i), a, e);
        end
        k++;
      end
    end
    checks++;
    if (nsd[i] - sd0 != nexp) begin
      failures++; $display("FAIL %s_sample_done got=%0d expected=%0d", name, nsd[i] - sd0, nexp);
    end
    checks++;
    if (viol[i] != v0) begin
      failures++; $display("FAIL %s_pulse_shape got=%0d expected=0", name, viol[i] - v0);
    end
  endtask

  task automatic test_timeout();
    int n;
    mode[0] = M_SILENT;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    checks++;
    if (tr[0] !== 1'b1) begin failures++; $display("FAIL timeout_issue tr got=%b expected=1", tr[0]); end
    n = 0;
    while (n < 50) begin
      tick();
      if (err[0] === 1'b1) break;
      n++;
    end
    checks++;
    if (n != TO) begin failures++; $display("FAIL timeout_wait_cycles got=%0d expected=%0d", n, TO); end
    checks++;
    if (err[0] !== 1'b1 || code[0] !== 2'b01) begin
      failures++; $display("FAIL timeout_code err=%b code=%b expected 1 01", err[0], code[0]);
    end
    checks++;
    if (busy[0] !== 1'b0 || tr[0] !== 1'b0 || vl[0] !== 1'b0) begin
      failures++; $display("FAIL timeout_quiet busy=%b tr=%b vl=%b expected 0 0 0", busy[0], tr[0], vl[0]);
    end
  endtask

  task automatic test_no_bpo();
    int n, sd0;
    mode[0] = M_NOBPO; sd0 = nsd[0];
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    checks++;
    if (err[0] !== 1'b0) begin failures++; $display("FAIL no_bpo_start_clears err got=%b expected=0", err[0]); end
    n = 0;
    while (!err[0] && n < 200) begin tick(); n++; end
    checks++;
    if (err[0] !== 1'b1 || code[0] !== 2'b10) begin
      failures++; $display("FAIL no_bpo_code err=%b code=%b expected 1 10", err[0], code[0]);
    end
    checks++;
    if (nsd[0] != sd0 || addr[0] !== 8'd0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL no_bpo_state done_pulses=%0d addr=%0d busy=%b expected 0 0 0", nsd[0] - sd0, addr[0], busy[0]);
    end
  endtask

  task automatic test_bph_val();
    int n, sd0;
    logic found;
    mode[0] = M_BPHVAL; sd0 = nsd[0]; found = 1'b0;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      tick(); n++;
      if (is_val[0] && (ph[0][1] || ph[0][0])) found = 1'b1;
    end
    checks++;
    if (!found || err[0] !== 1'b0) begin
      failures++; $display("FAIL bph_val_window found=%b err=%b expected 1 0", found, err[0]);
    end
    tick();
    checks++;
    if (err[0] !== 1'b1 || code[0] !== 2'b11) begin
      failures++; $display("FAIL bph_val_code err=%b code=%b expected 1 11", err[0], code[0]);
    end
    checks++;
    if (nsd[0] - sd0 != 2 || addr[0] !== 8'd2) begin
      failures++; $display("FAIL bph_val_progress done_pulses=%0d addr=%0d expected 2 2", nsd[0] - sd0, addr[0]);
    end
  endtask

  task automatic test_abort();
    int n, sd0;
    logic [3:0] prev;
    mode[0] = M_NORMAL; sd0 = nsd[0];
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    n = 0;
    while (!(tr[0] && addr[0] == 8'd1) && n < 100) begin tick(); n++; end
    checks++;
    if (tr[0] !== 1'b1 || addr[0] !== 8'd1) begin
      failures++; $display("FAIL abort_second_issue tr=%b addr=%0d expected 1 1", tr[0], addr[0]);
    end
    tick();
    checks++;
    if (ph[0] === 4'b0000 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL abort_model_active phase=%b busy=%b expected nonzero 1", ph[0], busy[0]);
    end
    abort[0] = 1'b1; prev = ph[0]; tick(); abort[0] = 1'b0; n = 1;
    while (busy[0] && n < 50) begin prev = ph[0]; tick(); n++; end
    checks++;
    if (busy[0] !== 1'b0 || n != slen[0] + 1 || prev !== 4'b0000) begin
      failures++; $display("FAIL abort_drain busy=%b cycles=%0d last_phase=%b expected 0 %0d 0000", busy[0], n, prev, slen[0] + 1);
    end
    checks++;
    if (nsd[0] - sd0 != 1 || err[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++; $display("FAIL abort_quiet done_pulses=%0d err=%b done=%b expected 1 0 0", nsd[0] - sd0, err[0], done[0]);
    end
    start[0] = 1'b1; abort[0] = 1'b1; tick(); start[0] = 1'b0; abort[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1 || tr[0] !== 1'b1 || addr[0] !== 8'd0 || epoch[0] !== 8'd0 || is_val[0] !== 1'b0) begin
      failures++; $display("FAIL abort_restart busy=%b tr=%b addr=%0d epoch=%0d is_val=%b expected 1 1 0 0 0",
                           busy[0], tr[0], addr[0], epoch[0], is_val[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] a0, e0;
    n = 0;
    while (!(ph[0] == 4'b0100 && addr[0] == 8'd1) && n < 100) begin tick(); n++; end
    checks++;
    if (ph[0] !== 4'b0100 || addr[0] !== 8'd1 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_reach_wait_done phase=%b addr=%0d busy=%b expected 0100 1 1", ph[0], addr[0], busy[0]);
    end
    a0 = addr[0]; e0 = epoch[0];
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    checks++;
    if (addr[0] !== a0 || epoch[0] !== e0 || tr[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_start_ignored addr=%0d epoch=%0d tr=%b busy=%b expected %0d %0d 0 1",
                           addr[0], epoch[0], tr[0], busy[0], a0, e0);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({tr[0], vl[0], sdone[0], busy[0], done[0], err[0], is_val[0], code[0], addr[0], epoch[0]} !== 25'd0) begin
      failures++; $display("FAIL async_reset_outputs got=%h expected=0",
                           {tr[0], vl[0], sdone[0], busy[0], done[0], err[0], is_val[0], code[0], addr[0], epoch[0]});
    end
    checks++;
    if (done[1] !== 1'b0) begin failures++; $display("FAIL async_reset_done_dut1 got=%b expected=0", done[1]); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    abort[0] = 1'b0; abort[1] = 1'b0;
    mode[0] = M_NORMAL; mode[1] = M_NORMAL;
    test_reset();
    test_full_run(0, "run_a");
    test_full_run(0, "run_b");
    test_full_run(1, "no_val");
    test_timeout();
    test_no_bpo();
    test_bph_val();
    test_full_run(0, "after_err");
    test_abort();
    test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (viol[i] != 0) begin failures++; $display("FAIL pulse_shape dut%0d got=%0d expected=0", i, viol[i]); end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
